vending_machine: RTL and testbench



---
 rtl/vending_machine_pkg.sv | 27 ++
 rtl/vending_machine_seg7.sv | 25 ++
 rtl/vending_machine.sv | 181 ++++++++++++++++++
 tb/tb_vending_machine.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/vending_machine_pkg.sv
// -----------------------------------------------------------------------------
// vending_machine_pkg
// Shared types and constants for the vending controller:
//   - state_e       : controller state encoding (IDLE / READY / VEND)
//   - ITEM_*        : item code constants carried on item_select / item_dispensed
//   - SEG7_TABLE    : active-high {g,f,e,d,c,b,a} patterns for digits 0..9
// -----------------------------------------------------------------------------
package vending_machine_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    VEND  = 2'd2
  } state_e;

  localparam logic [1:0] ITEM_NONE = 2'd0;
  localparam logic [1:0] ITEM_1    = 2'd1;
  localparam logic [1:0] ITEM_2    = 2'd2;
  localparam logic [1:0] ITEM_3    = 2'd3;

  // Index 0 is the rightmost entry of the concatenation.
  localparam logic [9:0][6:0] SEG7_TABLE = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage : vending_machine_pkg

// File: rtl/vending_machine_seg7.sv
// -----------------------------------------------------------------------------
// vending_machine_seg7
// Combinational decimal digit to seven-segment encoder.
// Ports:
//   digit_i  in  4  decimal digit 0..9 (10..15 blank the display)
//   seg_o    out 7  active-high pattern, bit order {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module vending_machine_seg7
  import vending_machine_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  // Table lookup; out-of-range codes produce a blank display.
  always_comb begin
    seg_o = 7'h00;
    if (digit_i <= 4'd9) begin
      seg_o = SEG7_TABLE[digit_i];
    end else begin
      seg_o = 7'h00;
    end
  end

endmodule : vending_machine_seg7

// File: rtl/vending_machine.sv
// -----------------------------------------------------------------------------
// vending_machine
// Credit/selection vending controller. Coins and dispense presses are counted
// on 0->1 transitions of level inputs; a vend pulses the item code for one
// cycle and deducts the price. Leftover credit is kept for later purchases.
//
// Ports:
//   clk             in   1  rising-edge clock
//   rst             in   1  synchronous reset, active-high
//   item_select     in   2  0 = no request, 1..3 = item code
//   coin_insert     in   1  coin acceptor level (each rise = one coin)
//   item_dispense   in   1  dispense button level (each rise = one request)
//   display         out  7  current credit (binary, or seven-segment digit)
//   item_dispensed  out  2  item code for one cycle on a vend, else 0
//
// Build option: define VENDING_MACHINE_SEG7_EN to drive display with the
// seven-segment pattern of (credit / COIN_VALUE) mod 10 instead of binary.
// COIN_VALUE must be nonzero; MAX_CREDIT must be <= 127.
// -----------------------------------------------------------------------------
module vending_machine
  import vending_machine_pkg::*;
#(
  parameter int unsigned COIN_VALUE = 5,
  parameter int unsigned PRICE_1    = 10,
  parameter int unsigned PRICE_2    = 15,
  parameter int unsigned PRICE_3    = 20,
  parameter int unsigned MAX_CREDIT = 127
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] item_select,
  input  logic       coin_insert,
  input  logic       item_dispense,
  output logic [6:0] display,
  output logic [1:0] item_dispensed
);

  localparam logic [7:0] COIN_V = 8'(COIN_VALUE);
  localparam logic [7:0] MAX_C  = 8'(MAX_CREDIT);

`ifdef VENDING_MACHINE_SEG7_EN
  localparam logic [6:0] DISPLAY_RST = SEG7_TABLE[0];
`else
  localparam logic [6:0] DISPLAY_RST = 7'd0;
`endif

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] credit_q, credit_d;
  logic       coin_q, disp_q;
  logic [1:0] item_dispensed_q, item_dispensed_d;
  logic [6:0] display_q, display_d;

  logic       coin_rise_s, disp_rise_s, vend_s;
  logic [7:0] price_s;
  logic [8:0] credit_sum_s;

  assign coin_rise_s = coin_insert & ~coin_q;
  assign disp_rise_s = item_dispense & ~disp_q;

  // Price of the currently latched selection.
  always_comb begin
    price_s = 8'd0;
    case (sel_q)
      ITEM_1:  price_s = 8'(PRICE_1);
      ITEM_2:  price_s = 8'(PRICE_2);
      ITEM_3:  price_s = 8'(PRICE_3);
      default: price_s = 8'd0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and selection logic. A successful vend keeps sel so the VEND
  // cycle can present it; a select arriving in that same cycle is dropped.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    vend_s  = 1'b0;
    case (state_q)
      IDLE, READY: begin
        if ((state_q == READY) && disp_rise_s && (credit_q >= price_s)) begin
          vend_s  = 1'b1;
          state_d = VEND;
        end else if (item_select != ITEM_NONE) begin
          sel_d   = item_select;
          state_d = READY;
        end else begin
          state_d = state_q;
        end
      end
      VEND: begin
        state_d = IDLE;
        sel_d   = ITEM_NONE;
      end
      default: begin
        state_d = IDLE;
        sel_d   = ITEM_NONE;
      end
    endcase
  end

  // Credit update: deduction and coin both apply, result saturates.
  always_comb begin
    credit_sum_s = {1'b0, credit_q}
                 - (vend_s      ? {1'b0, price_s} : 9'd0)
                 + (coin_rise_s ? {1'b0, COIN_V}  : 9'd0);
    if (credit_sum_s > {1'b0, MAX_C}) begin
      credit_d = MAX_C;
    end else begin
      credit_d = credit_sum_s[7:0];
    end
  end

`ifdef VENDING_MACHINE_SEG7_EN
  logic [7:0] coin_count_s;
  logic [3:0] digit_s;
  logic [6:0] seg_s;

  assign coin_count_s = credit_d / COIN_V;
  assign digit_s      = 4'(coin_count_s % 8'd10);

  vending_machine_seg7 u_seg7 (
    .digit_i (digit_s),
    .seg_o   (seg_s)
  );
`endif

  // Output decode, computed from next-cycle values so outputs are registered.
  always_comb begin
    item_dispensed_d = ITEM_NONE;
    if (vend_s) begin
      item_dispensed_d = sel_q;
    end else begin
      item_dispensed_d = ITEM_NONE;
    end
`ifdef VENDING_MACHINE_SEG7_EN
    display_d = seg_s;
`else
    display_d = credit_d[6:0];
`endif
  end

  // Datapath registers. Edge history resets high so inputs held through reset
  // are not counted until released and pressed again.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= ITEM_NONE;
      credit_q <= 8'd0;
      coin_q   <= 1'b1;
      disp_q   <= 1'b1;
    end else begin
      sel_q    <= sel_d;
      credit_q <= credit_d;
      coin_q   <= coin_insert;
      disp_q   <= item_dispense;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      item_dispensed_q <= ITEM_NONE;
      display_q        <= DISPLAY_RST;
    end else begin
      item_dispensed_q <= item_dispensed_d;
      display_q        <= display_d;
    end
  end

  assign item_dispensed = item_dispensed_q;
  assign display        = display_q;

endmodule : vending_machine

// File: tb/tb_vending_machine.sv
// -----------------------------------------------------------------------------
// tb_vending_machine
// Directed table of per-cycle vectors with expected credit and vended item,
// followed by hand-written sequences for held inputs, saturation and
// simultaneous coin/vend. Expected display is derived from expected credit.
// -----------------------------------------------------------------------------
module tb_vending_machine;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] item_select;
  logic       coin_insert;
  logic       item_dispense;
  logic [6:0] display;
  logic [1:0] item_dispensed;

  int n_vec = 0;
  int n_err = 0;

  vending_machine dut (
    .clk            (clk),
    .rst            (rst),
    .item_select    (item_select),
    .coin_insert    (coin_insert),
    .item_dispense  (item_dispense),
    .display        (display),
    .item_dispensed (item_dispensed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] sel;
    logic       coin;
    logic       disp;
    int         credit;
    logic [1:0] id;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [6:0] disp_of(input int credit);
`ifdef VENDING_MACHINE_SEG7_EN
    logic [6:0] p;
    case ((credit / 5) % 10)
      0: p = 7'h3F;  1: p = 7'h06;  2: p = 7'h5B;  3: p = 7'h4F;  4: p = 7'h66;
      5: p = 7'h6D;  6: p = 7'h7D;  7: p = 7'h07;  8: p = 7'h7F;  9: p = 7'h6F;
      default: p = 7'h00;
    endcase
    return p;
`else
    return 7'(credit);
`endif
  endfunction

  task automatic add(input logic r, input logic [1:0] s, input logic c,
                     input logic d, input int cr, input logic [1:0] id);
    vec_t v;
    v.rst = r; v.sel = s; v.coin = c; v.disp = d; v.credit = cr; v.id = id;
    vecs.push_back(v);
  endtask

  // Apply inputs, clock once, then settle past the edge before sampling.
  task automatic cyc(input logic r, input logic [1:0] s, input logic c, input logic d);
    rst = r; item_select = s; coin_insert = c; item_dispense = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int credit, input logic [1:0] id);
    n_vec++;
    if (display !== disp_of(credit)) begin
      n_err++;
      $display("FAIL %s display: got %h expected %h (credit %0d)", name, display, disp_of(credit), credit);
    end
    n_vec++;
    if (item_dispensed !== id) begin
      n_err++;
      $display("FAIL %s item_dispensed: got %0d expected %0d", name, item_dispensed, id);
    end
  endtask

  initial begin
    int vend_cnt;
    rst = 1'b1; item_select = 2'd0; coin_insert = 1'b1; item_dispense = 1'b0;

    //   rst  sel  coin disp credit id
    add(1'b1, 2'd0, 1'b1, 1'b0,  0, 2'd0);  // reset, coin held high
    add(1'b1, 2'd0, 1'b1, 1'b0,  0, 2'd0);
    add(1'b0, 2'd0, 1'b1, 1'b0,  0, 2'd0);  // still held: no coin
    add(1'b0, 2'd0, 1'b0, 1'b0,  0, 2'd0);
    add(1'b0, 2'd0, 1'b1, 1'b0,  5, 2'd0);  // reasserted: one coin
    add(1'b0, 2'd0, 1'b0, 1'b0,  5, 2'd0);
    add(1'b0, 2'd1, 1'b0, 1'b0,  5, 2'd0);  // select item 1
    add(1'b0, 2'd0, 1'b1, 1'b0, 10, 2'd0);
    add(1'b0, 2'd0, 1'b0, 1'b0, 10, 2'd0);
    add(1'b0, 2'd0, 1'b0, 1'b1,  0, 2'd1);  // vend item 1
    add(1'b0, 2'd0, 1'b0, 1'b0,  0, 2'd0);  // back to idle
    add(1'b0, 2'd0, 1'b0, 1'b1,  0, 2'd0);  // dispense in idle ignored
    add(1'b0, 2'd0, 1'b0, 1'b0,  0, 2'd0);
    add(1'b0, 2'd2, 1'b0, 1'b0,  0, 2'd0);  // select item 2
    add(1'b0, 2'd0, 1'b1, 1'b0,  5, 2'd0);
    add(1'b0, 2'd0, 1'b0, 1'b0,  5, 2'd0);
    add(1'b0, 2'd0, 1'b0, 1'b1,  5, 2'd0);  // denied: 5 < 15
    add(1'b0, 2'd0, 1'b0, 1'b0,  5, 2'd0);
    add(1'b0, 2'd0, 1'b1, 1'b0, 10, 2'd0);
    add(1'b0, 2'd0, 1'b0, 1'b0, 10, 2'd0);
    add(1'b0, 2'd0, 1'b1, 1'b0, 15, 2'd0);  // three coins total
    add(1'b0, 2'd0, 1'b0, 1'b0, 15, 2'd0);
    add(1'b0, 2'd0, 1'b0, 1'b1,  0, 2'd2);  // vend item 2
    add(1'b0, 2'd0, 1'b0, 1'b0,  0, 2'd0);
    add(1'b0, 2'd1, 1'b1, 1'b0,  5, 2'd0);  // select 1 with coin
    add(1'b0, 2'd0, 1'b0, 1'b0,  5, 2'd0);
    add(1'b0, 2'd0, 1'b1, 1'b0, 10, 2'd0);
    add(1'b0, 2'd0, 1'b0, 1'b0, 10, 2'd0);
    add(1'b0, 2'd0, 1'b0, 1'b1,  0, 2'd1);  // vend item 1
    add(1'b0, 2'd3, 1'b1, 1'b0,  5, 2'd0);  // coin credits during VEND
    add(1'b0, 2'd0, 1'b0, 1'b0,  5, 2'd0);
    add(1'b0, 2'd1, 1'b0, 1'b0,  5, 2'd0);  // select 1, credit 5
    add(1'b0, 2'd0, 1'b1, 1'b0, 10, 2'd0);
    add(1'b1, 2'd0, 1'b1, 1'b0,  0, 2'd0);  // reset mid-operation
    add(1'b0, 2'd0, 1'b0, 1'b0,  0, 2'd0);
    add(1'b0, 2'd0, 1'b0, 1'b1,  0, 2'd0);  // selection was discarded

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rst, vecs[i].sel, vecs[i].coin, vecs[i].disp);
      check($sformatf("vec%0d", i), vecs[i].credit, vecs[i].id);
    end
    cyc(1'b0, 2'd0, 1'b0, 1'b0);

    // Coin held high for 20 cycles counts once.
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 2'd0, 1'b1, 1'b0);
      if (i == 0 || i == 19) check("coin_hold", 5, 2'd0);
    end
    cyc(1'b0, 2'd1, 1'b0, 1'b0);
    cyc(1'b0, 2'd0, 1'b1, 1'b0);
    check("pre_hold_vend", 10, 2'd0);

    // Dispense held high vends once only.
    cyc(1'b0, 2'd0, 1'b0, 1'b1);
    check("disp_hold_first", 0, 2'd1);
    vend_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 2'd1, 1'b0, 1'b1);
      if (item_dispensed != 2'd0) vend_cnt++;
    end
    n_vec++;
    if (vend_cnt != 0) begin
      n_err++;
      $display("FAIL disp_hold_extra: got %0d extra vends expected 0", vend_cnt);
    end
    cyc(1'b0, 2'd0, 1'b0, 1'b0);
    check("disp_hold_after", 0, 2'd0);

    // Saturation: 26 coins from zero.
    for (int i = 0; i < 26; i++) begin
      cyc(1'b0, 2'd0, 1'b1, 1'b0);
      if (i == 2)  check("coins3", 15, 2'd0);
      if (i == 9)  check("coins10", 50, 2'd0);
      if (i == 24) check("coins25", 125, 2'd0);
      cyc(1'b0, 2'd0, 1'b0, 1'b0);
    end
    check("saturate", 127, 2'd0);

    // Select item 3, then vend with a coin edge in the same cycle.
    cyc(1'b0, 2'd3, 1'b0, 1'b0);
    check("sel3", 127, 2'd0);
    cyc(1'b0, 2'd0, 1'b1, 1'b1);
    check("vend_with_coin", 112, 2'd3);
    cyc(1'b0, 2'd0, 1'b0, 1'b0);
    check("after_vend3", 112, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_vending_machine
